// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, entry layout and saturating-counter helpers for branch_predictor
package bp_pkg;

    localparam int unsigned PC_W_DEF  = 16;
    localparam int unsigned IDX_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 2;

    localparam int unsigned CNT_ALLOC_DEF = 1 << (CNT_W_DEF - 1);

    typedef struct packed {
        logic                           valid;
        logic [PC_W_DEF-IDX_W_DEF-1:0]  tag;
        logic [CNT_W_DEF-1:0]           cnt;
        logic [PC_W_DEF-1:0]            target;
    } bp_entry_t;

    function automatic logic [31:0] cnt_alloc(int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    function automatic logic [31:0] cnt_next(logic [31:0] cnt, logic taken, int unsigned cnt_w);
        logic [31:0] max;
        max = (32'd1 << cnt_w) - 32'd1;
        return taken ? ((cnt == max) ? cnt : cnt + 32'd1)
                     : ((cnt == 32'd0) ? cnt : cnt - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: IF-stage lookup and ID-stage resolve signals; stat outputs exist only with BP_STATS_EN
interface branch_predictor_if #(parameter int PC_W = 16);

    logic [PC_W-1:0] lk_pc_i;
    logic            lk_hit_o;
    logic            lk_taken_o;
    logic [PC_W-1:0] lk_target_o;
    logic            upd_valid_i;
    logic [PC_W-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [PC_W-1:0] upd_target_i;
    logic            upd_pred_taken_i;
    logic [PC_W-1:0] upd_pred_target_i;
    logic            mispredict_o;
    logic [PC_W-1:0] redirect_pc_o;
`ifdef BP_STATS_EN
    logic [31:0]     stat_lookups_o;
    logic [31:0]     stat_updates_o;
    logic [31:0]     stat_mispred_o;

    modport slave (
        input  lk_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        output lk_hit_o, lk_taken_o, lk_target_o, mispredict_o, redirect_pc_o,
               stat_lookups_o, stat_updates_o, stat_mispred_o
    );

    modport master (
        output lk_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        input  lk_hit_o, lk_taken_o, lk_target_o, mispredict_o, redirect_pc_o,
               stat_lookups_o, stat_updates_o, stat_mispred_o
    );
`else
    modport slave (
        input  lk_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        output lk_hit_o, lk_taken_o, lk_target_o, mispredict_o, redirect_pc_o
    );

    modport master (
        output lk_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        input  lk_hit_o, lk_taken_o, lk_target_o, mispredict_o, redirect_pc_o
    );
`endif

endinterface

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: one combinational saturating step of a CNT_W-bit direction counter
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] cnt_o
);

    assign cnt_o = CNT_W'(cnt_next(32'(cnt_i), taken_i, CNT_W));

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters; BP_STATS_EN adds 32-bit event counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);

    localparam int TAG_W = PC_W - IDX_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] ALLOC = CNT_W'(cnt_alloc(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [CNT_W-1:0] cnt;
        logic [PC_W-1:0]  target;
    } entry_t;

    entry_t           tbl_q [DEPTH];
    entry_t           tbl_d [DEPTH];
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    entry_t           lk_e, up_e;
    logic             lk_hit, lk_taken, up_hit, mispredict;
    logic [CNT_W-1:0] up_cnt;

    assign lk_idx = bus.lk_pc_i[IDX_W-1:0];
    assign lk_tag = bus.lk_pc_i[PC_W-1:IDX_W];
    assign up_idx = bus.upd_pc_i[IDX_W-1:0];
    assign up_tag = bus.upd_pc_i[PC_W-1:IDX_W];
    assign lk_e   = tbl_q[lk_idx];
    assign up_e   = tbl_q[up_idx];

    assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
    assign lk_taken = lk_hit && lk_e.cnt[CNT_W-1];
    assign up_hit   = up_e.valid && (up_e.tag == up_tag);

    assign bus.lk_hit_o    = lk_hit;
    assign bus.lk_taken_o  = lk_taken;
    assign bus.lk_target_o = lk_taken ? lk_e.target : '0;

    assign mispredict = bus.upd_valid_i &&
                        ((bus.upd_taken_i != bus.upd_pred_taken_i) ||
                         (bus.upd_taken_i && bus.upd_pred_taken_i &&
                          (bus.upd_target_i != bus.upd_pred_target_i)));

    assign bus.mispredict_o  = mispredict;
    assign bus.redirect_pc_o = !mispredict ? '0 :
                               bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + PC_W'(1);

    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .cnt_i   (up_e.cnt),
        .taken_i (bus.upd_taken_i),
        .cnt_o   (up_cnt)
    );

    // Next table: train the counter on a hit, allocate only on a taken miss
    always_comb begin
        tbl_d = tbl_q;
        if (bus.upd_valid_i && up_hit) begin
            tbl_d[up_idx].cnt = up_cnt;
            if (bus.upd_taken_i) tbl_d[up_idx].target = bus.upd_target_i;
        end else if (bus.upd_valid_i && bus.upd_taken_i) begin
            tbl_d[up_idx] = '{valid: 1'b1, tag: up_tag, cnt: ALLOC, target: bus.upd_target_i};
        end
    end

    // Table register; reset wins over any update presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) tbl_q <= '{default: '0};
        else     tbl_q <= tbl_d;
    end

`ifdef BP_STATS_EN
    logic [31:0] lookups_q, updates_q, mispred_q;

    // Free-running event counters, wrapping at 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            updates_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_q + 32'(lk_hit);
            updates_q <= updates_q + 32'(bus.upd_valid_i);
            mispred_q <= mispred_q + 32'(mispredict);
        end
    end

    assign bus.stat_lookups_o = lookups_q;
    assign bus.stat_updates_o = updates_q;
    assign bus.stat_mispred_o = mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus hand-written multi-cycle sequences for branch_predictor
module tb_branch_predictor;

    typedef struct {
        logic        rst;
        logic [15:0] lk_pc;
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        upt;
        logic [15:0] uptgt;
        logic        e_hit;
        logic        e_tk;
        logic [15:0] e_tgt;
        logic        e_mp;
        logic [15:0] e_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] m_lk = '0, m_up = '0, m_mp = '0;
    vec_t tab [24];

    branch_predictor_if #(.PC_W(16)) bus ();

    branch_predictor #(.PC_W(16), .IDX_W(4), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [15:0] lk, logic uv, logic [15:0] upc, logic ut,
                                logic [15:0] utgt, logic upt, logic [15:0] uptgt, logic h,
                                logic tk, logic [15:0] tgt, logic mp, logic [15:0] rd);
        vec_t v;
        v = '{r, lk, uv, upc, ut, utgt, upt, uptgt, h, tk, tgt, mp, rd};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic ok;
        @(negedge clk);
        rst                   = v.rst;
        bus.lk_pc_i           = v.lk_pc;
        bus.upd_valid_i       = v.uv;
        bus.upd_pc_i          = v.upc;
        bus.upd_taken_i       = v.ut;
        bus.upd_target_i      = v.utgt;
        bus.upd_pred_taken_i  = v.upt;
        bus.upd_pred_target_i = v.uptgt;
        #1;
        ok = bus.lk_hit_o === v.e_hit && bus.lk_taken_o === v.e_tk && bus.lk_target_o === v.e_tgt &&
             bus.mispredict_o === v.e_mp && bus.redirect_pc_o === v.e_rd;
`ifdef BP_STATS_EN
        ok = ok && bus.stat_lookups_o === m_lk && bus.stat_updates_o === m_up &&
             bus.stat_mispred_o === m_mp;
        if (!ok)
            $display("FAIL stats vec %0d: got lk=%0d up=%0d mp=%0d exp lk=%0d up=%0d mp=%0d", n_vec,
                     bus.stat_lookups_o, bus.stat_updates_o, bus.stat_mispred_o, m_lk, m_up, m_mp);
`endif
        if (!ok) begin
            n_bad++;
            $display("FAIL vec %0d: got hit=%b tk=%b tgt=%h mp=%b rd=%h exp hit=%b tk=%b tgt=%h mp=%b rd=%h",
                     n_vec, bus.lk_hit_o, bus.lk_taken_o, bus.lk_target_o, bus.mispredict_o,
                     bus.redirect_pc_o, v.e_hit, v.e_tk, v.e_tgt, v.e_mp, v.e_rd);
        end
        n_vec++;
        if (v.rst) begin
            m_lk = '0;
            m_up = '0;
            m_mp = '0;
        end else begin
            m_lk = m_lk + 32'(v.e_hit);
            m_up = m_up + 32'(v.uv);
            m_mp = m_mp + 32'(v.e_mp);
        end
    endtask

    initial begin
        tab[0]  = mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        tab[1]  = mk(0, 16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040);
        tab[2]  = mk(0, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000);
        tab[3]  = mk(0, 16'h0012, 1, 16'h0012, 0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0040, 1, 16'h0013);
        tab[4]  = mk(0, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
        tab[5]  = mk(0, 16'h0012, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
        tab[6]  = mk(0, 16'h0012, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
        tab[7]  = mk(0, 16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0040);
        tab[8]  = mk(0, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
        tab[9]  = mk(0, 16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0040);
        tab[10] = mk(0, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000);
        tab[11] = mk(0, 16'h0022, 1, 16'h0012, 1, 16'h0044, 1, 16'h0040, 0, 0, 16'h0000, 1, 16'h0044);
        tab[12] = mk(0, 16'h0012, 1, 16'h0012, 1, 16'h0044, 1, 16'h0044, 1, 1, 16'h0044, 0, 16'h0000);
        tab[13] = mk(0, 16'h0022, 1, 16'h0022, 1, 16'h0100, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0100);
        tab[14] = mk(0, 16'h0022, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h0000);
        tab[15] = mk(0, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        tab[16] = mk(0, 16'h0022, 1, 16'h0032, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h0000);
        tab[17] = mk(0, 16'h0022, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h0000);
        tab[18] = mk(0, 16'hFFFF, 1, 16'hFFFF, 1, 16'h0777, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0777);
        tab[19] = mk(0, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h0777, 1, 1, 16'h0777, 1, 16'h0000);
        tab[20] = mk(0, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
        tab[21] = mk(1, 16'h0005, 1, 16'h0005, 1, 16'h0055, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0055);
        tab[22] = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        tab[23] = mk(0, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);

        bus.lk_pc_i = '0;
        bus.upd_valid_i = 1'b0;
        bus.upd_pc_i = '0;
        bus.upd_taken_i = 1'b0;
        bus.upd_target_i = '0;
        bus.upd_pred_taken_i = 1'b0;
        bus.upd_pred_target_i = '0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 24; i++) apply(tab[i]);

        apply(mk(0, 16'h0009, 1, 16'h0009, 1, 16'h00A0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h00A0));
        apply(mk(0, 16'h0009, 0, 16'h0009, 0, 16'h0000, 1, 16'h00A0, 1, 1, 16'h00A0, 0, 16'h0000));
        apply(mk(0, 16'h0009, 0, 16'h0009, 0, 16'h0000, 1, 16'h00A0, 1, 1, 16'h00A0, 0, 16'h0000));
        apply(mk(0, 16'h0009, 1, 16'h0009, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h00A0, 0, 16'h0000));
        apply(mk(0, 16'h0009, 1, 16'h0009, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000));
        apply(mk(0, 16'h0009, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000));
        apply(mk(1, 16'h0009, 1, 16'h0009, 1, 16'h00BB, 1, 16'h00A0, 1, 0, 16'h0000, 1, 16'h00BB));
        apply(mk(0, 16'h0009, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
